// File: rtl/sram_controller_pkg.sv
// sram_ctrl_pkg
// Shared types and constants for the MEM-stage SRAM controller.
//   sram_state_t      : controller FSM states (IDLE, LO, HI, DONE)
//   SRAM_DW / SRAM_AW : external SRAM data / halfword-address widths
//   DEFAULT_BASE_ADDR : byte address of the first data word
//   halfword_addr()   : builds the 19-bit SRAM address from a word index
//                       and the halfword select bit
package sram_ctrl_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 19;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  // Top address bit is always 0: only 2^17 words are reachable.
  function automatic logic [SRAM_AW-1:0] halfword_addr(input logic [16:0] word_idx,
                                                      input logic        upper);
    return {1'b0, word_idx, upper};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if
// Pipeline-side bus between the ARM_Pr MEM stage and the SRAM controller.
//   wr_en      : store request, held while ready = 0
//   rd_en      : load request, held while ready = 0
//   address    : word-aligned byte address
//   write_data : store data
//   read_data  : load result, valid when ready = 1 after a load
//   ready      : 0 freezes the pipeline
// Modports: master = pipeline (MEM stage), slave = controller.
interface sram_controller_if;

  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller_phase_counter.sv
// sram_phase_counter
// Down-counter timing one halfword phase on the SRAM bus.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset (count -> 0)
//   load       : load load_value (takes priority over en)
//   load_value : start value, normally ACCESS_CYCLES-1
//   en         : count down while non-zero
//   last       : high on the final cycle of the phase (count == 0)
module sram_phase_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so an enabled counter with nothing loaded stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// sram_controller
// MEM-stage SRAM controller: splits one 32-bit load/store into two 16-bit
// halfword accesses (low half first) and stalls the pipeline via ready.
//   Parameters : ACCESS_CYCLES (cycles per halfword phase, >= 1),
//                BASE_ADDR (subtracted from the byte address before mapping)
//   clk, rst   : rising-edge clock, asynchronous active-low reset
//   bus        : sram_controller_if.slave (wr_en, rd_en, address,
//                write_data, read_data, ready)
//   SRAM_DQ    : bidirectional data, driven only while SRAM_WE_N = 0
//   SRAM_ADDR  : halfword address
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N : tied active (0)
//   SRAM_WE_N  : active-low write strobe
// Optional feature: define SRAM_WRITE_BUFFER_EN for posted writes (a store
// is acknowledged in the cycle it is seen and completes in the background).
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] PHASE_START = CW'(ACCESS_CYCLES - 1);

  sram_state_t        state;
  logic               is_write;
  logic [15:0]        wdata_hi;
  logic [16:0]        word_idx;
  logic [15:0]        rd_lo;
  logic [31:0]        read_data_q;
  logic [SRAM_DW-1:0] dq_out;
  logic               we_n;
  logic [SRAM_AW-1:0] sram_addr_q;

  logic               req;
  logic [31:0]        offset;
  logic               phase_load;
  logic               phase_en;
  logic               phase_last;
  logic               ready_c;
  logic               unused_offset_bits;

  assign req    = bus.wr_en | bus.rd_en;
  // Wrap-around subtraction; only bits [18:2] select the SRAM word.
  assign offset = bus.address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Reload at the start of LO (from IDLE) and at the start of HI.
  assign phase_load = ((state == IDLE) && req) || ((state == LO) && phase_last);
  assign phase_en   = (state == LO) || (state == HI);

  sram_phase_counter #(
    .WIDTH (CW)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load       (phase_load),
    .load_value (PHASE_START),
    .en         (phase_en),
    .last       (phase_last)
  );

  // Main FSM. Address, strobe and write data are registered so the SRAM
  // pins change only on clock edges. The low read half is parked in rd_lo
  // so read_data keeps the previous load result until this load completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      wdata_hi    <= '0;
      word_idx    <= '0;
      rd_lo       <= '0;
      read_data_q <= '0;
      dq_out      <= '0;
      we_n        <= 1'b1;
      sram_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LO;
            is_write    <= bus.wr_en;
            wdata_hi    <= bus.write_data[31:16];
            word_idx    <= offset[18:2];
            dq_out      <= bus.write_data[15:0];
            we_n        <= ~bus.wr_en;
            sram_addr_q <= halfword_addr(offset[18:2], 1'b0);
          end
        end
        LO: begin
          if (phase_last) begin
            state       <= HI;
            sram_addr_q <= halfword_addr(word_idx, 1'b1);
            dq_out      <= wdata_hi;
            if (!is_write) begin
              rd_lo <= SRAM_DQ;
            end
          end
        end
        HI: begin
          if (phase_last) begin
            state <= DONE;
            we_n  <= 1'b1;
            if (!is_write) begin
              read_data_q <= {SRAM_DQ, rd_lo};
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_WRITE_BUFFER_EN
  // Stores are posted: acknowledged in IDLE immediately. While a posted store
  // drains, the pipeline runs freely unless it presents a new request, which
  // waits for IDLE so a following load always sees the new data.
  always_comb begin
    ready_c = 1'b0;
    if (state == IDLE) begin
      ready_c = bus.wr_en | ~bus.rd_en;
    end else if (is_write) begin
      ready_c = ~req;
    end else begin
      ready_c = (state == DONE);
    end
  end
`else
  // Loads and stores both stall until DONE.
  always_comb begin
    ready_c = ((state == IDLE) && !req) || (state == DONE);
  end
`endif

  assign bus.ready     = ready_c;
  assign bus.read_data = read_data_q;

  assign SRAM_DQ   = we_n ? {SRAM_DW{1'bz}} : dq_out;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Bench for sram_controller with a behavioural 16-bit SRAM, a shadow word
// memory, and a queue of expected load results. Honours
// SRAM_WRITE_BUFFER_EN for the expected store/load stall lengths.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  localparam int          AC   = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LD_LAT = 2 * AC + 1;
`ifdef SRAM_WRITE_BUFFER_EN
  localparam int          ST_LAT  = 0;
  localparam int          B2B_LAT = 4 * AC + 2;
`else
  localparam int          ST_LAT  = 2 * AC + 1;
  localparam int          B2B_LAT = 2 * AC + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_controller_if bus ();

  wire  [15:0] sram_dq;
  logic [18:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  sram_controller #(
    .ACCESS_CYCLES (AC),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // Behavioural SRAM: reads drive the bus asynchronously, writes land on
  // each rising edge the strobe is low.
  logic [15:0] sramMem [0:524287];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sramMem[sram_addr] : 16'bz;
  always @(posedge clk) begin
    if (!ce_n && !we_n && !ub_n && !lb_n) sramMem[sram_addr] <= sram_dq;
  end

  int weLowTotal = 0;
  always @(negedge clk) begin
    if (we_n === 1'b0) weLowTotal++;
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] shadow [int];
  logic [31:0] expQ [$];
  logic [31:0] lastRead;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wordIndex(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'({15'b0, off[18:2]});
  endfunction

  // Called at a falling edge; drives a request, waits (bounded) for ready,
  // checks stall length and, for loads, pops the expected result. Returns
  // at the falling edge after the completing edge with the request held.
  task automatic applyStimulus(input string tag, input logic doWr, input logic doRd,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int expLatency);
    int   cycles;
    int   idx;
    logic isLoad;
    logic [31:0] exp;
    isLoad         = doRd && !doWr;
    idx            = wordIndex(addr);
    bus.wr_en      = doWr;
    bus.rd_en      = doRd;
    bus.address    = addr;
    bus.write_data = data;
    if (doWr) shadow[idx] = data;
    else if (isLoad) expQ.push_back(shadow.exists(idx) ? shadow[idx] : 32'h0);
    cycles = 0;
    #1;
    while (bus.ready !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (bus.ready !== 1'b1) checkOutput({tag, "_timeout"}, {31'b0, bus.ready}, 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLatency));
    if (isLoad) begin
      exp      = expQ.pop_front();
      lastRead = exp;
      checkOutput({tag, "_rdata"}, bus.read_data, exp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          we0;
    int          hw;
    logic [31:0] d;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;

    // Reset state while reset is held.
    #97;
    checkOutput("rst_ready", {31'b0, bus.ready}, 32'd1);
    checkOutput("rst_we_n", {31'b0, we_n}, 32'd1);
    checkOutput("rst_rdata", bus.read_data, 32'h0);
    checkOutput("rst_addr", {13'b0, sram_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(2);

    // First store: strobe length and halfword placement.
    we0 = weLowTotal;
    applyStimulus("store1", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, ST_LAT);
    idleCycles(8);
    checkOutput("store1_we_low", 32'(weLowTotal - we0), 32'(2 * AC));
    checkOutput("store1_mem0", {16'b0, sramMem[0]}, 32'h0000BEEF);
    checkOutput("store1_mem1", {16'b0, sramMem[1]}, 32'h0000DEAD);

    // Load back, then confirm the result holds through idle cycles.
    applyStimulus("load1", 1'b0, 1'b1, 32'd1024, 32'h0, LD_LAT);
    idleCycles(4);
    checkOutput("load1_hold", bus.read_data, lastRead);

    // Both requests asserted: treated as a store.
    applyStimulus("both", 1'b1, 1'b1, 32'd1028, 32'h12345678, ST_LAT);
    idleCycles(8);
    checkOutput("both_mem2", {16'b0, sramMem[2]}, 32'h00005678);
    checkOutput("both_mem3", {16'b0, sramMem[3]}, 32'h00001234);

    // Reset pulse during the HI phase of a load.
    bus.rd_en   = 1'b1;
    bus.address = 32'd1024;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_in_hi", {31'b0, sram_addr[0]}, 32'd1);
    bus.rd_en = 1'b0;
    #1;
    rst = 1'b0;
    #2;
    checkOutput("rstmid_rdata", bus.read_data, 32'h0);
    checkOutput("rstmid_we_n", {31'b0, we_n}, 32'd1);
    checkOutput("rstmid_addr", {13'b0, sram_addr}, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_ready", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    applyStimulus("load_after_rst", 1'b0, 1'b1, 32'd1028, 32'h0, LD_LAT);
    idleCycles(2);

    // Address below BASE wraps around.
    applyStimulus("wrap_store", 1'b1, 1'b0, 32'd0, 32'hA5A55A5A, ST_LAT);
    idleCycles(8);
    hw = 2 * wordIndex(32'd0);
    checkOutput("wrap_idx", 32'(hw), 32'h0003FE00);
    checkOutput("wrap_mem_lo", {16'b0, sramMem[19'(hw)]}, 32'h00005A5A);
    checkOutput("wrap_mem_hi", {16'b0, sramMem[19'(hw + 1)]}, 32'h0000A5A5);
    applyStimulus("wrap_load", 1'b0, 1'b1, 32'd0, 32'h0, LD_LAT);
    idleCycles(2);

    // Random stores, then loads in reverse order through the scoreboard.
    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      applyStimulus("rnd_store", 1'b1, 1'b0, 32'd1040 + 32'(4 * k), d, ST_LAT);
      idleCycles(8);
    end
    for (int k = 4; k >= 0; k--) begin
      applyStimulus("rnd_load", 1'b0, 1'b1, 32'd1040 + 32'(4 * k), 32'h0, LD_LAT);
      idleCycles(1);
    end

    // Store immediately followed by a load of the same word.
    idleCycles(2);
    d = $urandom;
    applyStimulus("b2b_store", 1'b1, 1'b0, 32'd1060, d, ST_LAT);
    applyStimulus("b2b_load", 1'b0, 1'b1, 32'd1060, 32'h0, B2B_LAT);
    idleCycles(8);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage SRAM controller between the ARM_Pr MEM stage and the external 16-bit SRAM. Turns one 32-bit load or store into two sequential 16-bit SRAM halfword accesses and stalls the pipeline through `ready` until the access completes. Drives every SRAM pin the SRAM model consumes: `SRAM_DQ`, `SRAM_ADDR`, and `SRAM_UB_N`/`LB_N`/`WE_N`/`CE_N`/`OE_N`.

## Interface
- `ACCESS_CYCLES`, 2: cycles each halfword phase is held on the SRAM bus (≥1).
- `BASE_ADDR`, 1024: byte address of the first data word; subtracted before mapping.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: store request, held by the pipeline while `ready`=0.
- `rd_en` in 1: load request, held while `ready`=0.
- `address` in 32: byte address, word aligned.
- `write_data` in 32: store data.
- `read_data` out 32: load result, valid when `ready`=1 after a load; held until the next load completes.
- `ready` out 1: 0 = freeze pipeline.
- `SRAM_DQ` inout 16: driven only while `SRAM_WE_N`=0, else high-Z.
- `SRAM_ADDR` out 19: halfword address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied 0.
- `SRAM_WE_N` out 1: active-low write strobe.

## Operation
- FSM states: IDLE, LO, HI, DONE. A phase counter runs 0..ACCESS_CYCLES-1 in LO and HI.
- IDLE with `wr_en|rd_en`:
  - Capture `address - BASE_ADDR` as `base`, plus `write_data` and the op type.
  - Go to LO. `wr_en` wins if both are asserted.
- LO: `SRAM_ADDR={1'b0,base[18:2],1'b0}`.
  - Write: `WE_N`=0, `DQ=wdata[15:0]`.
  - Read: capture `DQ` into `read_data[15:0]` on the last LO cycle.
- HI: `SRAM_ADDR={1'b0,base[18:2],1'b1}`.
  - Write: drive `wdata[31:16]`.
  - Read: capture into `[31:16]` on the last HI cycle.
- DONE: one cycle, then IDLE.
- `ready` (combinational) = (IDLE and no request) or DONE.
- Address arithmetic is 32-bit with wrap-around; only `base[18:2]` is used. There is no range error.
- Outside LO/HI writes: `WE_N`=1, `DQ`=Z, `SRAM_ADDR` holds its last value (0 after reset).

## Timing
- Request seen in IDLE at cycle 0: LO occupies cycles 1..AC, HI occupies AC+1..2AC, DONE occurs at 2AC+1. With AC=2, `ready`=1 at cycle 5.
- The pipeline advances on the DONE edge. A new request on the following cycle starts from IDLE again; there is no back-to-back overlap.
- Reset values: `ready`=1 (IDLE, no request), `read_data`=0, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `DQ`=Z, counter 0.
- Reset asserted mid-access aborts to IDLE immediately. A partially written word is left as-is, and `read_data` is cleared.
- Requests that change while `ready`=0 are ignored: the captured values are used.

## Configuration
- `SRAM_WRITE_BUFFER_EN`:
  - Defined: a store seen in IDLE gives `ready`=1 in the same cycle (posted write). The captured data finishes in the background through LO/HI/DONE.
  - Defined: any request arriving while the FSM is not IDLE gets `ready`=0 until IDLE, then is served normally. A load after a posted store therefore always returns the new data.
  - Undefined: stores stall for the full 2AC+1 cycles, the same as loads.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum `sram_state_t`;
  - `SRAM_DW`=16, `SRAM_AW`=19;
  - default `BASE_ADDR`.
- Sub-module `sram_phase_counter`: a parameterised down-counter with load and `last` flag, used for the LO and HI phases.

## Test plan
- Reset: `rst`=0 at 100 ns → `ready`=1, `SRAM_WE_N`=1, `DQ`=Z, `read_data`=0.
- Store `address`=1024, `write_data`=0xDEADBEEF, AC=2:
  - `WE_N` low 4 cycles;
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD;
  - `ready` high at cycle 5.
- Load `address`=1024 after that store → `read_data`=0xDEADBEEF at cycle 5, held through a following idle period.
- `wr_en` and `rd_en` both set, `address`=1028, `write_data`=0x12345678 → treated as a write: SRAM[2]=0x5678, SRAM[3]=0x1234.
- Reset pulse during HI of a load → IDLE next edge, `read_data`=0, `WE_N`=1; the next load completes normally.
- With `SRAM_WRITE_BUFFER_EN`: store immediately followed by a load of the same address:
  - `ready`=1 in the store cycle;
  - the load stalls until the store finishes, then returns the stored value.
